// File: rtl/axis_rr_grant_mux.sv
// Packet-level 2:1 AXI-Stream mux driven by an external round-robin arbiter, with a registered 2-entry skid buffer.
// Define AXIS_RR_MUX_TID_EN to add the m_axis_tid source-channel tag (0 = channel 1, 1 = channel 2).
module axis_rr_grant_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  axis_clk,
    input  logic                  axis_reset,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    input  logic [DATA_WIDTH-1:0] s2_axis_tdata,
    input  logic                  s2_axis_tvalid,
    input  logic                  s2_axis_tlast,
    output logic                  s2_axis_tready,
    output logic                  req_1,
    output logic                  req_2,
    input  logic                  gnt_1,
    input  logic                  gnt_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
`ifdef AXIS_RR_MUX_TID_EN
    output logic                  m_axis_tid,
`endif
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK1 = 2'd1,
        LOCK2 = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic                  main_valid_reg;
    logic [DATA_WIDTH-1:0] main_data_reg;
    logic                  main_last_reg;
    logic                  skid_valid_reg;
    logic [DATA_WIDTH-1:0] skid_data_reg;
    logic                  skid_last_reg;
    logic [CNT_WIDTH-1:0]  pkt_count_reg;

    logic                  fire_1;
    logic                  fire_2;
    logic                  in_fire;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;

`ifdef AXIS_RR_MUX_TID_EN
    logic main_tid_reg;
    logic skid_tid_reg;
    logic in_tid;
    assign in_tid     = (state_reg == LOCK2);
    assign m_axis_tid = main_tid_reg;
`endif

    // State register
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a grant only locks if its channel actually has a beat waiting
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (gnt_1 && s1_axis_tvalid) begin
                    state_next = LOCK1;
                end else if (gnt_2 && !gnt_1 && s2_axis_tvalid) begin
                    state_next = LOCK2;
                end
            end
            LOCK1: begin
                if (fire_1 && s1_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            LOCK2: begin
                if (fire_2 && s2_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic; requests are masked while reset is held so the arbiter sees nothing
    always_comb begin
        req_1          = s1_axis_tvalid && (state_reg == IDLE) && !axis_reset;
        req_2          = s2_axis_tvalid && (state_reg == IDLE) && !axis_reset;
        s1_axis_tready = (state_reg == LOCK1) && !skid_valid_reg;
        s2_axis_tready = (state_reg == LOCK2) && !skid_valid_reg;
    end

    assign fire_1  = s1_axis_tvalid && s1_axis_tready;
    assign fire_2  = s2_axis_tvalid && s2_axis_tready;
    assign in_fire = fire_1 || fire_2;
    assign in_data = (state_reg == LOCK2) ? s2_axis_tdata : s1_axis_tdata;
    assign in_last = (state_reg == LOCK2) ? s2_axis_tlast : s1_axis_tlast;

    // Skid buffer: the main register refills from the skid entry first, so order is preserved.
    // An input beat can never arrive while the skid entry is occupied because tready is gated on it.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_last_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_last_reg  <= 1'b0;
`ifdef AXIS_RR_MUX_TID_EN
            main_tid_reg   <= 1'b0;
            skid_tid_reg   <= 1'b0;
`endif
        end else if (!main_valid_reg || m_axis_tready) begin
            if (skid_valid_reg) begin
                main_valid_reg <= 1'b1;
                main_data_reg  <= skid_data_reg;
                main_last_reg  <= skid_last_reg;
                skid_valid_reg <= 1'b0;
`ifdef AXIS_RR_MUX_TID_EN
                main_tid_reg   <= skid_tid_reg;
`endif
            end else begin
                main_valid_reg <= in_fire;
                if (in_fire) begin
                    main_data_reg <= in_data;
                    main_last_reg <= in_last;
`ifdef AXIS_RR_MUX_TID_EN
                    main_tid_reg  <= in_tid;
`endif
                end
            end
        end else if (in_fire) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
            skid_last_reg  <= in_last;
`ifdef AXIS_RR_MUX_TID_EN
            skid_tid_reg   <= in_tid;
`endif
        end
    end

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            pkt_count_reg <= '0;
        end else if (in_fire && in_last) begin
            pkt_count_reg <= pkt_count_reg + 1'b1;
        end
    end

    assign m_axis_tvalid = main_valid_reg;
    assign m_axis_tdata  = main_data_reg;
    assign m_axis_tlast  = main_last_reg;
    assign pkt_count     = pkt_count_reg;

endmodule

// File: tb/tb_axis_rr_grant_mux.sv
// Randomized bench for axis_rr_grant_mux: a queue-based scoreboard predicts every output, ready and request.
module tb_axis_rr_grant_mux;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          axis_clk = 1'b0;
    logic          axis_reset;
    logic [DW-1:0] s1_axis_tdata, s2_axis_tdata, m_axis_tdata;
    logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
    logic          s2_axis_tvalid, s2_axis_tlast, s2_axis_tready;
    logic          req_1, req_2, gnt_1, gnt_2;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [CW-1:0] pkt_count;
`ifdef AXIS_RR_MUX_TID_EN
    logic          m_axis_tid;
`endif

    always #5 axis_clk = ~axis_clk;

    axis_rr_grant_mux #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .axis_clk       (axis_clk),
        .axis_reset     (axis_reset),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .s2_axis_tdata  (s2_axis_tdata),
        .s2_axis_tvalid (s2_axis_tvalid),
        .s2_axis_tlast  (s2_axis_tlast),
        .s2_axis_tready (s2_axis_tready),
        .req_1          (req_1),
        .req_2          (req_2),
        .gnt_1          (gnt_1),
        .gnt_2          (gnt_2),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
`ifdef AXIS_RR_MUX_TID_EN
        .m_axis_tid     (m_axis_tid),
`endif
        .m_axis_tready  (m_axis_tready),
        .pkt_count      (pkt_count)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          id;
    } beat_t;

    beat_t src_q1[$];
    beat_t src_q2[$];
    beat_t exp_q[$];     // beats accepted by the mux but not yet taken downstream
    int    lock_ch;      // 0 = no packet in progress, else locked channel
    int    pkt_model;
    int    n_checks;
    int    n_pass;
    int    ready_pct;
    int    valid_pct;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic add_pkt(input int ch, input int len, input logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d  = base + DW'(i);
            b.l  = (i == len - 1);
            b.id = (ch == 2);
            if (ch == 1) src_q1.push_back(b);
            else         src_q2.push_back(b);
        end
    endtask

    // Called just after a rising edge: present new source beats, grants and downstream ready
    task automatic drive_inputs();
        if (!s1_axis_tvalid) s1_axis_tvalid = (src_q1.size() > 0) && ($urandom_range(99) < valid_pct);
        if (!s2_axis_tvalid) s2_axis_tvalid = (src_q2.size() > 0) && ($urandom_range(99) < valid_pct);
        if (src_q1.size() > 0) begin s1_axis_tdata = src_q1[0].d; s1_axis_tlast = src_q1[0].l; end
        if (src_q2.size() > 0) begin s2_axis_tdata = src_q2[0].d; s2_axis_tlast = src_q2[0].l; end
        gnt_1 = (s1_axis_tvalid && lock_ch == 0) ? 1'($urandom_range(1)) : ($urandom_range(9) == 0);
        gnt_2 = (s2_axis_tvalid && lock_ch == 0) ? 1'($urandom_range(1)) : ($urandom_range(9) == 0);
        m_axis_tready = ($urandom_range(99) < ready_pct);
    endtask

    // One clock: compare at the falling edge, advance the model after the rising edge
    task automatic cycle();
        logic  fire1, fire2, ofire, g1, g2, v1, v2;
        beat_t b;
        @(negedge axis_clk);
        check("req_1", req_1, s1_axis_tvalid && lock_ch == 0);
        check("req_2", req_2, s2_axis_tvalid && lock_ch == 0);
        check("s1_tready", s1_axis_tready, lock_ch == 1 && exp_q.size() < 2);
        check("s2_tready", s2_axis_tready, lock_ch == 2 && exp_q.size() < 2);
        check("m_tvalid", m_axis_tvalid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("m_tdata", m_axis_tdata, exp_q[0].d);
            check("m_tlast", m_axis_tlast, exp_q[0].l);
`ifdef AXIS_RR_MUX_TID_EN
            check("m_tid", m_axis_tid, exp_q[0].id);
`endif
        end
        check("pkt_count", pkt_count, pkt_model & 16'hFFFF);
        fire1 = s1_axis_tvalid && lock_ch == 1 && exp_q.size() < 2;
        fire2 = s2_axis_tvalid && lock_ch == 2 && exp_q.size() < 2;
        ofire = exp_q.size() > 0 && m_axis_tready;
        g1 = gnt_1; g2 = gnt_2; v1 = s1_axis_tvalid; v2 = s2_axis_tvalid;
        @(posedge axis_clk);
        #1;
        if (ofire) void'(exp_q.pop_front());
        if (fire1 || fire2) begin
            if (fire1) begin b = src_q1.pop_front(); s1_axis_tvalid = 1'b0; end
            else       begin b = src_q2.pop_front(); s2_axis_tvalid = 1'b0; end
            exp_q.push_back(b);
            if (b.l) begin pkt_model++; lock_ch = 0; end
        end else if (lock_ch == 0) begin
            if (g1 && v1)           lock_ch = 1;
            else if (g2 && !g1 && v2) lock_ch = 2;
        end
        drive_inputs();
    endtask

    task automatic run_until_drained(input string tag, input int budget);
        int n;
        n = 0;
        while ((src_q1.size() > 0 || src_q2.size() > 0 || exp_q.size() > 0 || lock_ch != 0) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, n < budget, 1'b1);
    endtask

    task automatic model_reset();
        exp_q.delete(); src_q1.delete(); src_q2.delete();
        lock_ch = 0; pkt_model = 0;
        s1_axis_tvalid = 1'b0; s2_axis_tvalid = 1'b0;
    endtask

    initial begin
        int n;
        n_checks = 0; n_pass = 0;
        ready_pct = 100; valid_pct = 100;
        s1_axis_tdata = '0; s2_axis_tdata = '0; s1_axis_tlast = 0; s2_axis_tlast = 0;
        gnt_1 = 0; gnt_2 = 0; m_axis_tready = 1;
        model_reset();
        s1_axis_tvalid = 1'b1;
        axis_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge axis_clk);
            check("rst_m_tvalid", m_axis_tvalid, 0);
            check("rst_m_tdata", m_axis_tdata, 0);
            check("rst_req_1", req_1, 0);
            check("rst_s1_tready", s1_axis_tready, 0);
        end
        @(posedge axis_clk); #1;
        axis_reset = 1'b0;
        s1_axis_tvalid = 1'b0;

        // Single channel-1 packet with downstream always ready
        add_pkt(1, 3, 32'hA1);
        drive_inputs();
        run_until_drained("pktA", 60);
        check("pktA_count", pkt_count, 1);

        // Long randomized traffic on both channels with random backpressure
        ready_pct = 60; valid_pct = 70;
        for (int p = 0; p < 120; p++) add_pkt(1 + (p % 2), 1 + $urandom_range(4), $urandom);
        run_until_drained("random", 20000);

        // Reset after 2 of 4 beats of a channel-1 packet
        ready_pct = 100; valid_pct = 100;
        add_pkt(1, 4, 32'hC0);
        n = 0;
        while (src_q1.size() > 2 && n < 100) begin cycle(); n++; end
        check("midpkt_reached", n < 100, 1'b1);
        #1 axis_reset = 1'b1;
        #1;
        check("midrst_m_tvalid", m_axis_tvalid, 0);
        check("midrst_pkt_count", pkt_count, 0);
        check("midrst_s1_tready", s1_axis_tready, 0);
        model_reset();
        repeat (2) @(posedge axis_clk);
        #1 axis_reset = 1'b0;

        // Channel-2 packet after reset, with backpressure
        ready_pct = 50;
        add_pkt(2, 4, 32'hB0);
        drive_inputs();
        run_until_drained("pktB", 200);
        check("pktB_count", pkt_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
